// File: rtl/smi_arb_pkg.sv
// -----------------------------------------------------------------------------
// smi_arb_pkg
// Shared definitions for the SMI stream arbiter:
//   - arb_state_t : arbiter FSM state encoding
//   - CH_*        : channel codes as seen on o_active_ch and in the tag byte
//   - tag_byte()  : builds the per-burst tag byte {magic, 2'b00, channel}
//   - word_byte() : selects byte 3..0 of a 32-bit word (3 = MSB)
// -----------------------------------------------------------------------------
package smi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TAG       = 3'd1,
        ST_WAIT_WORD = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_END       = 3'd4
    } arb_state_t;

    localparam logic [1:0] CH_NONE = 2'b00;
    localparam logic [1:0] CH_09   = 2'b01;
    localparam logic [1:0] CH_24   = 2'b10;

    // Tag byte layout: magic nibble, two zero bits, channel code.
    function automatic logic [7:0] tag_byte(input logic [3:0] magic, input logic [1:0] ch);
        return {magic, 2'b00, ch};
    endfunction

    // Byte 3 is [31:24] (sent first), byte 0 is [7:0] (sent last).
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd3:    b = word[31:24];
            2'd2:    b = word[23:16];
            2'd1:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/smi_soe_sync.sv
// -----------------------------------------------------------------------------
// smi_soe_sync
// Brings the asynchronous SMI SOE strobe into the system clock domain through
// two flops and emits a one-cycle pulse for every falling edge.
// Ports:
//   clk        in  1  system clock
//   reset      in  1  synchronous active-high reset (flops reset to 1 = idle SOE)
//   async_in   in  1  raw SOE strobe from the pad
//   fall_pulse out 1  one-cycle pulse per falling edge of async_in
// -----------------------------------------------------------------------------
module smi_soe_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic fall_pulse
);

    logic q1_r;
    logic q2_r;

    // Two-flop synchroniser; idle level of SOE is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            q1_r <= 1'b1;
            q2_r <= 1'b1;
        end else begin
            q1_r <= async_in;
            q2_r <= q1_r;
        end
    end

    assign fall_pulse = q2_r & ~q1_r;

endmodule

// File: rtl/smi_stream_arbiter.sv
// -----------------------------------------------------------------------------
// smi_stream_arbiter
// Shares the SMI read channel between the 0.9 GHz and 2.4 GHz RX FIFOs.
// Bursts of BURST_WORDS words are drained per channel with round-robin
// arbitration; each burst is one tag byte followed by the payload MSB first,
// paced by falling edges of the SMI SOE strobe.
// Ports:
//   i_sys_clk / i_reset                 clock, synchronous active-high reset
//   i_enable                            gate for starting new bursts
//   o_fifo_09_pull / i_fifo_09_*        0.9 GHz FIFO pull, data (+1 cycle), empty
//   o_fifo_24_pull / i_fifo_24_*        2.4 GHz FIFO pull, data (+1 cycle), empty
//   i_smi_soe_se                        async SOE strobe, falling edge consumes
//   o_smi_data_out / o_smi_read_req     presented byte and its valid flag
//   o_active_ch                         burst owner (00 none, 01 0.9, 10 2.4)
//   o_burst_done                        pulse after the last byte is consumed
//   o_underrun                          sticky: consume with no byte presented
// -----------------------------------------------------------------------------
module smi_stream_arbiter #(
    parameter int         BURST_WORDS = 16,
    parameter logic [3:0] TAG_MAGIC   = 4'hA
) (
    input  logic        i_sys_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    output logic        o_fifo_09_pull,
    input  logic [31:0] i_fifo_09_pulled_data,
    input  logic        i_fifo_09_empty,
    output logic        o_fifo_24_pull,
    input  logic [31:0] i_fifo_24_pulled_data,
    input  logic        i_fifo_24_empty,
    input  logic        i_smi_soe_se,
    output logic [7:0]  o_smi_data_out,
    output logic        o_smi_read_req,
    output logic [1:0]  o_active_ch,
    output logic        o_burst_done,
    output logic        o_underrun
);

    import smi_arb_pkg::*;

    generate
        if (BURST_WORDS < 1 || BURST_WORDS > 255) begin : g_bad_burst_words
            $error("smi_stream_arbiter: BURST_WORDS must be within 1..255");
        end
    endgenerate

    localparam logic [7:0] BURST_LEN = 8'(BURST_WORDS);

    // Registered state and datapath.
    arb_state_t  state_r,      state_s;
    logic [1:0]  ch_r,         ch_s;
    logic        last_24_r,    last_24_s;     // 1: 2.4 GHz was served last
    logic [7:0]  data_r,       data_s;
    logic        byte_valid_r, byte_valid_s;
    logic        done_r,       done_s;
    logic        underrun_r,   underrun_s;
    logic [31:0] buf_r,        buf_s;         // one-word prefetch buffer
    logic        buf_full_r,   buf_full_s;
    logic        pend_r,       pend_s;        // a pull was issued last cycle
    logic [31:0] word_r,       word_s;        // word currently being shifted out
    logic [1:0]  byte_idx_r,   byte_idx_s;
    logic [7:0]  to_pull_r,    to_pull_s;     // words not yet pulled this burst
    logic [7:0]  to_show_r,    to_show_s;     // words not yet presented this burst

    logic        consume_s;
    logic        sel_empty_s;
    logic [31:0] sel_data_s;
    logic        pull_ok_s;
    logic        pull_s;
    logic [1:0]  pick_s;

    smi_soe_sync u_soe_sync (
        .clk        (i_sys_clk),
        .reset      (i_reset),
        .async_in   (i_smi_soe_se),
        .fall_pulse (consume_s)
    );

    // Route the owning channel's FIFO flag/data and pick the next burst owner.
    always_comb begin
        sel_empty_s = i_fifo_09_empty;
        sel_data_s  = i_fifo_09_pulled_data;
        pick_s      = CH_09;
        if (ch_r == CH_24) begin
            sel_empty_s = i_fifo_24_empty;
            sel_data_s  = i_fifo_24_pulled_data;
        end else begin
            sel_empty_s = i_fifo_09_empty;
            sel_data_s  = i_fifo_09_pulled_data;
        end
        // Tie goes to the channel not served last.
        if (!i_fifo_09_empty && !i_fifo_24_empty) begin
            pick_s = last_24_r ? CH_09 : CH_24;
        end else if (!i_fifo_09_empty) begin
            pick_s = CH_09;
        end else begin
            pick_s = CH_24;
        end
    end

    // Pull strobe: one outstanding pull, buffer empty, FIFO non-empty; in SHIFT
    // the prefetch only starts once the last byte of the current word is shown.
    always_comb begin
        pull_ok_s = (to_pull_r != 8'd0) && !buf_full_r && !pend_r && !sel_empty_s && !i_reset;
        case (state_r)
            ST_TAG, ST_WAIT_WORD: pull_s = pull_ok_s;
            ST_SHIFT:             pull_s = pull_ok_s && (byte_idx_r == 2'd0);
            default:              pull_s = 1'b0;
        endcase
    end

    assign o_fifo_09_pull = pull_s && (ch_r == CH_09);
    assign o_fifo_24_pull = pull_s && (ch_r == CH_24);

    // Next-state and datapath logic.
    always_comb begin
        state_s      = state_r;
        ch_s         = ch_r;
        last_24_s    = last_24_r;
        data_s       = data_r;
        byte_valid_s = byte_valid_r;
        done_s       = 1'b0;
        underrun_s   = underrun_r;
        buf_s        = buf_r;
        buf_full_s   = buf_full_r;
        pend_s       = 1'b0;
        word_s       = word_r;
        byte_idx_s   = byte_idx_r;
        to_pull_s    = to_pull_r;
        to_show_s    = to_show_r;

        // Word lands one cycle after its pull; buffer is empty whenever pend_r is set.
        if (pend_r) begin
            buf_s      = sel_data_s;
            buf_full_s = 1'b1;
        end else begin
            buf_s = buf_r;
        end

        if (pull_s) begin
            pend_s    = 1'b1;
            to_pull_s = to_pull_r - 8'd1;
        end else begin
            pend_s = 1'b0;
        end

        // A consume with nothing presented only raises the flag; no state moves.
        if (consume_s && !byte_valid_r) begin
            underrun_s = 1'b1;
        end else begin
            underrun_s = underrun_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (i_enable && (!i_fifo_09_empty || !i_fifo_24_empty)) begin
                    ch_s         = pick_s;
                    data_s       = tag_byte(TAG_MAGIC, pick_s);
                    byte_valid_s = 1'b1;
                    to_pull_s    = BURST_LEN;
                    to_show_s    = BURST_LEN;
                    state_s      = ST_TAG;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_TAG: begin
                if (consume_s) begin
                    if (buf_full_r) begin
                        word_s       = buf_r;
                        data_s       = buf_r[31:24];
                        byte_idx_s   = 2'd3;
                        buf_full_s   = 1'b0;
                        to_show_s    = to_show_r - 8'd1;
                        byte_valid_s = 1'b1;
                        state_s      = ST_SHIFT;
                    end else begin
                        byte_valid_s = 1'b0;
                        state_s      = ST_WAIT_WORD;
                    end
                end else begin
                    state_s = ST_TAG;
                end
            end
            ST_WAIT_WORD: begin
                if (buf_full_r) begin
                    word_s       = buf_r;
                    data_s       = buf_r[31:24];
                    byte_idx_s   = 2'd3;
                    buf_full_s   = 1'b0;
                    to_show_s    = to_show_r - 8'd1;
                    byte_valid_s = 1'b1;
                    state_s      = ST_SHIFT;
                end else begin
                    state_s = ST_WAIT_WORD;
                end
            end
            ST_SHIFT: begin
                if (consume_s) begin
                    if (byte_idx_r != 2'd0) begin
                        byte_idx_s = byte_idx_r - 2'd1;
                        data_s     = word_byte(word_r, byte_idx_r - 2'd1);
                    end else if (to_show_r == 8'd0) begin
                        byte_valid_s = 1'b0;
                        state_s      = ST_END;
                    end else if (buf_full_r) begin
                        word_s       = buf_r;
                        data_s       = buf_r[31:24];
                        byte_idx_s   = 2'd3;
                        buf_full_s   = 1'b0;
                        to_show_s    = to_show_r - 8'd1;
                        byte_valid_s = 1'b1;
                        state_s      = ST_SHIFT;
                    end else begin
                        byte_valid_s = 1'b0;
                        state_s      = ST_WAIT_WORD;
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_END: begin
                done_s    = 1'b1;
                last_24_s = (ch_r == CH_24);
                ch_s      = CH_NONE;
                state_s   = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register for FSM and datapath.
    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            state_r      <= ST_IDLE;
            ch_r         <= CH_NONE;
            last_24_r    <= 1'b1;
            data_r       <= 8'h00;
            byte_valid_r <= 1'b0;
            done_r       <= 1'b0;
            underrun_r   <= 1'b0;
            buf_r        <= 32'h0000_0000;
            buf_full_r   <= 1'b0;
            pend_r       <= 1'b0;
            word_r       <= 32'h0000_0000;
            byte_idx_r   <= 2'd0;
            to_pull_r    <= 8'd0;
            to_show_r    <= 8'd0;
        end else begin
            state_r      <= state_s;
            ch_r         <= ch_s;
            last_24_r    <= last_24_s;
            data_r       <= data_s;
            byte_valid_r <= byte_valid_s;
            done_r       <= done_s;
            underrun_r   <= underrun_s;
            buf_r        <= buf_s;
            buf_full_r   <= buf_full_s;
            pend_r       <= pend_s;
            word_r       <= word_s;
            byte_idx_r   <= byte_idx_s;
            to_pull_r    <= to_pull_s;
            to_show_r    <= to_show_s;
        end
    end

    assign o_smi_data_out = data_r;
    assign o_smi_read_req = byte_valid_r;
    assign o_active_ch    = ch_r;
    assign o_burst_done   = done_r;
    assign o_underrun     = underrun_r;

endmodule

// File: tb/tb_smi_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_smi_stream_arbiter
// Bench for smi_stream_arbiter (BURST_WORDS = 2). The expected byte stream is
// produced by a byte-level model: per burst, pick the owner from the queued
// words and round-robin history, emit the tag, then each word MSB first.
// FIFOs are modelled as queues; the host side pulses SOE per byte.
// -----------------------------------------------------------------------------
module tb_smi_stream_arbiter;

    localparam int BW = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic        soe = 1'b1;
    logic        pull09, pull24;
    logic [31:0] pd09 = 32'h0, pd24 = 32'h0;
    logic        e09 = 1'b1, e24 = 1'b1;
    logic [7:0]  dout;
    logic        rreq, done, urun;
    logic [1:0]  ach;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    smi_stream_arbiter #(.BURST_WORDS(BW), .TAG_MAGIC(4'hA)) dut (
        .i_sys_clk             (clk),
        .i_reset               (rst),
        .i_enable              (en),
        .o_fifo_09_pull        (pull09),
        .i_fifo_09_pulled_data (pd09),
        .i_fifo_09_empty       (e09),
        .o_fifo_24_pull        (pull24),
        .i_fifo_24_pulled_data (pd24),
        .i_fifo_24_empty       (e24),
        .i_smi_soe_se          (soe),
        .o_smi_data_out        (dout),
        .o_smi_read_req        (rreq),
        .o_active_ch           (ach),
        .o_burst_done          (done),
        .o_underrun            (urun)
    );

    // FIFO contents as seen by the DUT, and the model's copies.
    logic [31:0] dq09[$];
    logic [31:0] dq24[$];
    logic [31:0] mq09[$];
    logic [31:0] mq24[$];

    // FIFO behaviour: data valid the cycle after a pull; empty flag registered.
    always @(posedge clk) begin
        if (pull09 && dq09.size() > 0) pd09 <= dq09.pop_front();
        if (pull24 && dq24.size() > 0) pd24 <= dq24.pop_front();
        e09 <= (dq09.size() == 0);
        e24 <= (dq24.size() == 0);
    end

    // Byte-level model state.
    logic [7:0] m_bytes[$];
    int         m_words_left = 0;
    logic [1:0] m_ch     = 2'b00;
    logic       m_last24 = 1'b1;
    logic       m_urun   = 1'b0;

    // Per-cycle observation state.
    int   hi_cnt   = 0;
    int   pulls09  = 0;
    int   pulls24  = 0;
    int   dut_done = 0;
    logic prev_pull = 1'b0;
    logic prev_done = 1'b0;

    logic [7:0] lit1 [9] = '{8'hA1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] tags2[4] = '{8'hA1, 8'hA2, 8'hA1, 8'hA2};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one cycle and check the per-cycle rules on the outputs.
    task automatic tick();
        @(negedge clk);
        if (soe) hi_cnt++; else hi_cnt = 0;
        if (pull09) pulls09++;
        if (pull24) pulls24++;
        if (done)   dut_done++;
        if (!rst) begin
            chk("pull_exclusive", 32'(pull09 & pull24), 32'd0);
            chk("pull_on_empty",  32'((pull09 & e09) | (pull24 & e24)), 32'd0);
            chk("pull_spacing",   32'((pull09 | pull24) & prev_pull), 32'd0);
            chk("pull_owner",     32'((pull09 && ach != 2'b01) || (pull24 && ach != 2'b10)), 32'd0);
            chk("req_owner",      32'(rreq && ach == 2'b00), 32'd0);
            chk("done_width",     32'(done & prev_done), 32'd0);
            if (hi_cnt >= 4) chk("underrun_flag", 32'(urun), 32'(m_urun));
        end
        prev_pull = pull09 | pull24;
        prev_done = done;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input int ch, input logic [31:0] w);
        if (ch == 9) begin
            dq09.push_back(w);
            mq09.push_back(w);
        end else begin
            dq24.push_back(w);
            mq24.push_back(w);
        end
    endtask

    // Model: next byte the host must see and the channel that owns it.
    task automatic m_next(output logic [7:0] b, output logic [1:0] ch);
        logic [31:0] w;
        if (m_bytes.size() == 0) begin
            if (m_words_left == 0) begin
                if (mq09.size() > 0 && mq24.size() > 0) m_ch = m_last24 ? 2'b01 : 2'b10;
                else if (mq09.size() > 0)               m_ch = 2'b01;
                else                                    m_ch = 2'b10;
                m_bytes.push_back({4'hA, 2'b00, m_ch});
                m_words_left = BW;
            end else begin
                w = 32'hDEAD_BEEF;
                if (m_ch == 2'b01 && mq09.size() > 0)      w = mq09.pop_front();
                else if (m_ch == 2'b10 && mq24.size() > 0) w = mq24.pop_front();
                for (int k = 3; k >= 0; k--) m_bytes.push_back(w[8*k +: 8]);
                m_words_left--;
            end
        end
        b  = m_bytes.pop_front();
        ch = m_ch;
        if (m_bytes.size() == 0 && m_words_left == 0) m_last24 = (m_ch == 2'b10);
    endtask

    // Host read: wait for a presented byte, compare, then strobe SOE low/high.
    task automatic host_read(input string name, output logic [7:0] got, output logic [7:0] exp);
        logic [1:0] ech;
        int t;
        m_next(exp, ech);
        t = 0;
        while (rreq !== 1'b1 && t < 300) begin
            tick();
            t++;
        end
        got = dout;
        if (rreq !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: read_req stayed %0b, expected byte %0h", name, rreq, exp);
        end else begin
            chk({name, "_byte"}, 32'(dout), 32'(exp));
            chk({name, "_ch"},   32'(ach),  32'(ech));
            soe = 1'b0;
            ticks($urandom_range(2, 4));
            soe = 1'b1;
            ticks($urandom_range(2, 4));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        soe = 1'b1;
        dq09.delete(); dq24.delete(); mq09.delete(); mq24.delete(); m_bytes.delete();
        m_words_left = 0;
        m_last24     = 1'b1;
        m_urun       = 1'b0;
        ticks(2);
        rst = 1'b0;
        ticks(2);
    endtask

    initial begin
        logic [7:0] got, exp;
        int d0, p0, p1, n09, n24, nb;

        @(negedge clk);
        do_reset();
        // Reset state.
        chk("rst_req",   32'(rreq), 32'd0);
        chk("rst_data",  32'(dout), 32'd0);
        chk("rst_ch",    32'(ach),  32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_urun",  32'(urun), 32'd0);
        chk("rst_pull",  32'(pull09 | pull24), 32'd0);

        // Test 1: basic burst from the 0.9 GHz FIFO.
        push(9, 32'h11223344);
        push(9, 32'h55667788);
        p0 = pulls09; d0 = dut_done;
        for (int i = 0; i < 9; i++) begin
            host_read("t1", got, exp);
            chk("t1_lit_dut",   32'(got), 32'(lit1[i]));
            chk("t1_lit_model", 32'(exp), 32'(lit1[i]));
        end
        ticks(5);
        chk("t1_pulls", 32'(pulls09 - p0), 32'd2);
        chk("t1_done",  32'(dut_done - d0), 32'd1);

        // Test 2: round-robin with both FIFOs loaded.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(9,  $urandom);
            push(24, $urandom);
        end
        d0 = dut_done; p0 = pulls09; p1 = pulls24;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 1 + 4 * BW; i++) begin
                host_read("t2", got, exp);
                if (i == 0) chk("t2_tag", 32'(got), 32'(tags2[b]));
            end
        end
        ticks(5);
        chk("t2_done",    32'(dut_done - d0), 32'd4);
        chk("t2_pulls09", 32'(pulls09 - p0),  32'd4);
        chk("t2_pulls24", 32'(pulls24 - p1),  32'd4);

        // Test 3: 2.4 GHz FIFO starves after the first word.
        do_reset();
        push(24, 32'h0BADF00D);
        d0 = dut_done;
        for (int i = 0; i < 5; i++) host_read("t3a", got, exp);
        ticks(10);
        chk("t3_req_low", 32'(rreq), 32'd0);
        chk("t3_ch_held", 32'(ach),  32'd2);
        push(24, 32'hCAFEF00D);
        host_read("t3b", got, exp);
        chk("t3_resume", 32'(got), 32'hCA);
        for (int i = 0; i < 3; i++) host_read("t3b", got, exp);
        ticks(5);
        chk("t3_no_urun", 32'(urun), 32'd0);
        chk("t3_done",    32'(dut_done - d0), 32'd1);

        // Test 4: underrun while waiting for a word.
        do_reset();
        push(9, 32'h01020304);
        for (int i = 0; i < 5; i++) host_read("t4a", got, exp);
        ticks(5);
        chk("t4_wait_req", 32'(rreq), 32'd0);
        soe = 1'b0;
        m_urun = 1'b1;
        ticks(3);
        soe = 1'b1;
        ticks(5);
        chk("t4_underrun", 32'(urun), 32'd1);
        push(9, 32'h05060708);
        for (int i = 0; i < 4; i++) begin
            host_read("t4b", got, exp);
            chk("t4_after", 32'(got), 32'(i + 5));
        end
        ticks(5);
        chk("t4_sticky", 32'(urun), 32'd1);

        // Test 5: reset in the middle of a burst.
        do_reset();
        push(9, 32'hA5A5_5A5A);
        push(9, 32'h1234_5678);
        for (int i = 0; i < 3; i++) host_read("t5a", got, exp);
        rst = 1'b1;
        tick();
        chk("t5_req",  32'(rreq), 32'd0);
        chk("t5_data", 32'(dout), 32'd0);
        chk("t5_ch",   32'(ach),  32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_urun", 32'(urun), 32'd0);
        chk("t5_pull", 32'(pull09 | pull24), 32'd0);
        do_reset();
        push(9, 32'h9988_7766);
        push(9, 32'h5544_3322);
        for (int i = 0; i < 1 + 4 * BW; i++) begin
            host_read("t5b", got, exp);
            if (i == 0) chk("t5_fresh_tag", 32'(got), 32'hA1);
        end

        // Test 6: enable dropped during word 0.
        do_reset();
        push(9, $urandom); push(9, $urandom);
        push(24, $urandom); push(24, $urandom);
        d0 = dut_done;
        host_read("t6a", got, exp);
        host_read("t6a", got, exp);
        en = 1'b0;
        for (int i = 0; i < 7; i++) host_read("t6a", got, exp);
        ticks(10);
        chk("t6_done", 32'(dut_done - d0), 32'd1);
        ticks(30);
        chk("t6_hold_req", 32'(rreq), 32'd0);
        chk("t6_hold_ch",  32'(ach),  32'd0);
        en = 1'b1;
        for (int i = 0; i < 1 + 4 * BW; i++) begin
            host_read("t6b", got, exp);
            if (i == 0) chk("t6_next_tag", 32'(got), 32'hA2);
        end

        // Randomized rounds: random fill levels, payloads and SOE pacing.
        do_reset();
        d0 = dut_done;
        nb = 0;
        for (int r = 0; r < 4; r++) begin
            n09 = BW * $urandom_range(0, 3);
            n24 = BW * $urandom_range(1, 3);
            for (int i = 0; i < n09; i++) push(9,  $urandom);
            for (int i = 0; i < n24; i++) push(24, $urandom);
            for (int b = 0; b < (n09 + n24) / BW; b++) begin
                for (int i = 0; i < 1 + 4 * BW; i++) host_read("rnd", got, exp);
                nb++;
            end
            ticks(5);
        end
        chk("rnd_done", 32'(dut_done - d0), 32'(nb));
        chk("rnd_no_urun", 32'(urun), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
